// File: rtl/int_seq.sv
// -----------------------------------------------------------------------------
// int_seq : interrupt / reset entry sequencer for the 6502 core.
//
// Latches NMI falling edges, arbitrates NMI / IRQ / BRK at instruction
// boundaries and, while busy, owns the memory bus. It pushes PCH, PCL and P to
// page 1, fetches the vector and hands the new PC to control with a one-cycle
// load strobe. Reset enters directly at the vector fetch and skips the pushes.
//
// Optional feature macro: INT_SEQ_HIJACK_EN
//   defined   : an NMI that becomes pending during the push states of an
//               IRQ/BRK entry takes over the sequence, so the NMI vector is
//               fetched. The B bit already chosen for the push is kept.
//   undefined : the source is fixed when IDLE is left; a late NMI waits for
//               the next boundary.
// -----------------------------------------------------------------------------
module int_seq #(
   parameter logic [15:0] NMI_VEC = 16'hFFFA,
   parameter logic [15:0] RST_VEC = 16'hFFFC,
   parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_nmi_n,
   input  logic        i_irq_n,
   input  logic        i_boundary,
   input  logic        i_brk,
   input  logic        i_i_flag,
   input  logic [15:0] i_pc_in,
   input  logic [7:0]  i_p_in,
   input  logic [7:0]  i_s_in,
   input  logic [7:0]  i_mem_din,
   output logic        o_busy,
   output logic [15:0] o_mem_addr,
   output logic [7:0]  o_mem_dout,
   output logic        o_mem_we,
   output logic        o_s_dec,
   output logic [15:0] o_pc_out,
   output logic        o_pc_ld,
   output logic        o_set_i,
   output logic [1:0]  o_int_ack
);

   // Sequencer states
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PUSH_PCH = 3'd1;
   localparam logic [2:0] S_PUSH_PCL = 3'd2;
   localparam logic [2:0] S_PUSH_P   = 3'd3;
   localparam logic [2:0] S_VEC_LO   = 3'd4;
   localparam logic [2:0] S_VEC_HI   = 3'd5;
   localparam logic [2:0] S_LOAD_PC  = 3'd6;

   // Source encoding doubles as the int_ack code presented at LOAD_PC
   localparam logic [1:0] SRC_RESET = 2'b00;
   localparam logic [1:0] SRC_IRQ   = 2'b01;
   localparam logic [1:0] SRC_NMI   = 2'b10;
   localparam logic [1:0] SRC_BRK   = 2'b11;

   logic [2:0]  r_state;
   logic [1:0]  r_src;
   logic        r_bflag;     // B bit to push, frozen at IDLE exit
   logic        r_nmi_pend;
   logic        r_nmi_prev;
   logic [7:0]  r_vec_lo;
   logic [15:0] r_pc_out;

   logic [2:0]  w_state_nxt;
   logic [1:0]  w_src_nxt;
   logic        w_bflag_nxt;
   logic        w_nmi_edge;
   logic        w_nmi_req;
   logic        w_irq_req;
   logic        w_nmi_clr;
   logic        w_in_push;
   logic [15:0] w_vec;

   // Vector base address for a given source
   function automatic logic [15:0] f_vector(input logic [1:0] src);
      logic [15:0] v;
      case (src)
         SRC_NMI: v = NMI_VEC;
         SRC_IRQ: v = IRQ_VEC;
         SRC_BRK: v = IRQ_VEC;
         default: v = RST_VEC;
      endcase
      return v;
   endfunction

   // A falling edge seen this cycle is eligible at the same boundary
   assign w_nmi_edge = r_nmi_prev & ~i_nmi_n;
   assign w_nmi_req  = r_nmi_pend | w_nmi_edge;
   assign w_irq_req  = ~i_irq_n & ~i_i_flag;
   assign w_in_push  = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) ||
                       (r_state == S_PUSH_P);
   assign w_vec      = f_vector(r_src);

   // pending NMI is consumed when the sequence enters VEC_LO on its behalf
   assign w_nmi_clr  = (r_state == S_PUSH_P) && (w_src_nxt == SRC_NMI);

   // Next-state, source arbitration and optional NMI hijack
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_bflag_nxt = r_bflag;
      case (r_state)
         S_IDLE: begin
            if (i_boundary) begin
               if (w_nmi_req) begin
                  w_src_nxt   = SRC_NMI;
                  w_bflag_nxt = 1'b0;
                  w_state_nxt = S_PUSH_PCH;
               end else if (w_irq_req) begin
                  w_src_nxt   = SRC_IRQ;
                  w_bflag_nxt = 1'b0;
                  w_state_nxt = S_PUSH_PCH;
               end else if (i_brk) begin
                  w_src_nxt   = SRC_BRK;
                  w_bflag_nxt = 1'b1;
                  w_state_nxt = S_PUSH_PCH;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PUSH_PCH: w_state_nxt = S_PUSH_PCL;
         S_PUSH_PCL: w_state_nxt = S_PUSH_P;
         S_PUSH_P:   w_state_nxt = S_VEC_LO;
         S_VEC_LO:   w_state_nxt = S_VEC_HI;
         S_VEC_HI:   w_state_nxt = S_LOAD_PC;
         S_LOAD_PC:  w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
`ifdef INT_SEQ_HIJACK_EN
      if (w_in_push && r_nmi_pend && ((r_src == SRC_IRQ) || (r_src == SRC_BRK))) begin
         w_src_nxt = SRC_NMI;
      end else begin
         w_src_nxt = w_src_nxt;
      end
`endif
   end

   // Control state: FSM, source, B bit and NMI edge latch
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_VEC_LO;
         r_src      <= SRC_RESET;
         r_bflag    <= 1'b0;
         r_nmi_pend <= 1'b0;
         r_nmi_prev <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_src      <= w_src_nxt;
         r_bflag    <= w_bflag_nxt;
         r_nmi_prev <= i_nmi_n;
         // a new edge wins over the clear so it is never lost
         r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
      end
   end

   // Vector capture: low byte first, then assemble the full PC
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vec_lo <= 8'h00;
         r_pc_out <= 16'h0000;
      end else if (r_state == S_VEC_LO) begin
         r_vec_lo <= i_mem_din;
      end else if (r_state == S_VEC_HI) begin
         r_pc_out <= {i_mem_din, r_vec_lo};
      end
   end

   assign o_pc_out = r_pc_out;

   // Bus and strobe decode from the current state
   always_comb begin
      o_busy     = 1'b1;
      o_mem_addr = 16'h0000;
      o_mem_dout = 8'h00;
      o_mem_we   = 1'b0;
      o_s_dec    = 1'b0;
      o_pc_ld    = 1'b0;
      o_set_i    = 1'b0;
      o_int_ack  = 2'b00;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
         end
         S_PUSH_PCH: begin
            o_mem_addr = {8'h01, i_s_in};
            o_mem_dout = i_pc_in[15:8];
            o_mem_we   = 1'b1;
            o_s_dec    = 1'b1;
         end
         S_PUSH_PCL: begin
            o_mem_addr = {8'h01, i_s_in};
            o_mem_dout = i_pc_in[7:0];
            o_mem_we   = 1'b1;
            o_s_dec    = 1'b1;
         end
         S_PUSH_P: begin
            o_mem_addr = {8'h01, i_s_in};
            o_mem_dout = {i_p_in[7:6], 1'b1, r_bflag, i_p_in[3:0]};
            o_mem_we   = 1'b1;
            o_s_dec    = 1'b1;
         end
         S_VEC_LO: begin
            o_mem_addr = w_vec;
         end
         S_VEC_HI: begin
            o_mem_addr = w_vec + 16'h0001;
         end
         S_LOAD_PC: begin
            o_pc_ld   = 1'b1;
            o_set_i   = 1'b1;
            o_int_ack = r_src;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_int_seq.sv
// -----------------------------------------------------------------------------
// tb_int_seq : self-checking bench for int_seq. Expected stack writes and PC
// loads are queued when stimulus is driven and popped as the DUT produces them.
// Define INT_SEQ_HIJACK_EN for both files to check the hijack build.
// -----------------------------------------------------------------------------
module tb_int_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        boundary = 1'b0;
   logic        brk = 1'b0;
   logic        i_flag = 1'b0;
   logic [15:0] pc_in = 16'h0000;
   logic [7:0]  p_in = 8'h00;
   logic [7:0]  s_reg;
   logic [7:0]  mem_din;
   logic        busy, mem_we, s_dec, pc_ld, set_i;
   logic [15:0] mem_addr, pc_out;
   logic [7:0]  mem_dout;
   logic [1:0]  int_ack;

   logic        s_load = 1'b0;
   logic [7:0]  s_load_val = 8'h00;

   int errors = 0;
   int checks = 0;

   logic [23:0] wq[$];   // {addr, data}
   logic [17:0] pcq[$];  // {pc, ack}

   logic        smp_busy, smp_we, smp_ld, smp_sdec;
   logic [15:0] smp_addr;

   int_seq dut (
      .i_clk(clk), .i_rst(rst), .i_nmi_n(nmi_n), .i_irq_n(irq_n),
      .i_boundary(boundary), .i_brk(brk), .i_i_flag(i_flag),
      .i_pc_in(pc_in), .i_p_in(p_in), .i_s_in(s_reg), .i_mem_din(mem_din),
      .o_busy(busy), .o_mem_addr(mem_addr), .o_mem_dout(mem_dout),
      .o_mem_we(mem_we), .o_s_dec(s_dec), .o_pc_out(pc_out),
      .o_pc_ld(pc_ld), .o_set_i(set_i), .o_int_ack(int_ack)
   );

   always #5 clk = ~clk;

   // Stack pointer owned by the bench's model of control
   always @(posedge clk) begin
      if (s_load) s_reg <= s_load_val;
      else if (s_dec) s_reg <= s_reg - 8'd1;
   end

   // Vector ROM: NMI=9000, RST=1234, IRQ=8000
   always_comb begin
      case (mem_addr)
         16'hFFFA: mem_din = 8'h00;
         16'hFFFB: mem_din = 8'h90;
         16'hFFFC: mem_din = 8'h34;
         16'hFFFD: mem_din = 8'h12;
         16'hFFFE: mem_din = 8'h00;
         16'hFFFF: mem_din = 8'h80;
         default:  mem_din = 8'hEE;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: sample and score at negedge, then move to just after posedge
   task automatic cyc();
      logic [23:0] w;
      logic [17:0] p;
      @(negedge clk);
      smp_busy = busy; smp_we = mem_we; smp_ld = pc_ld;
      smp_sdec = s_dec; smp_addr = mem_addr;
      if (mem_we) begin
         if (wq.size() == 0) chk("unexpected_write", {8'h00, mem_addr, mem_dout}, 32'h0);
         else begin
            w = wq.pop_front();
            chk("stack_write", {8'h00, mem_addr, mem_dout}, {8'h00, w});
            chk("s_dec_with_write", {31'd0, s_dec}, 32'd1);
         end
      end else if (s_dec) begin
         chk("s_dec_without_write", {31'd0, s_dec}, 32'd0);
      end
      if (pc_ld) begin
         if (pcq.size() == 0) chk("unexpected_pc_ld", {14'd0, pc_out, int_ack}, 32'h0);
         else begin
            p = pcq.pop_front();
            chk("pc_out_ack", {14'd0, pc_out, int_ack}, {14'd0, p});
            chk("set_i", {31'd0, set_i}, 32'd1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Wait for pc_ld with a bound; returns cycles counted from the current one
   task automatic wait_ld(output int lat);
      lat = 0;
      do begin
         lat++;
         cyc();
      end while (!smp_ld && lat < 20);
      if (!smp_ld) chk("pc_ld_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic        nmi0;
      logic        irq_n;
      logic        iflag;
      logic        brk;
      logic [7:0]  s;
      logic [7:0]  p;
      logic [15:0] pc;
      int          xnmi;     // cycle after boundary with an extra NMI edge, 0 = none
      logic        take;
      logic [7:0]  exp_p;
      logic [15:0] exp_pc;
      logic [1:0]  exp_ack;
   } vec_t;

   vec_t tbl [10];

   // Apply one boundary vector and score the whole entry sequence
   task automatic run_vec(input int idx, input vec_t r);
      logic [7:0] s8;
      int lat;
      s_load = 1'b1; s_load_val = r.s; pc_in = r.pc; p_in = r.p;
      cyc();
      s_load = 1'b0;
      if (r.take) begin
         s8 = r.s;
         wq.push_back({8'h01, s8, r.pc[15:8]}); s8 = s8 - 8'd1;
         wq.push_back({8'h01, s8, r.pc[7:0]});  s8 = s8 - 8'd1;
         wq.push_back({8'h01, s8, r.exp_p});
         pcq.push_back({r.exp_pc, r.exp_ack});
      end
      boundary = 1'b1; brk = r.brk; irq_n = r.irq_n; i_flag = r.iflag;
      nmi_n = r.nmi0 ? 1'b0 : 1'b1;
      cyc();
      chk($sformatf("v%0d_busy_at_boundary", idx), {31'd0, smp_busy}, 32'd0);
      boundary = 1'b0; brk = 1'b0; irq_n = 1'b1; i_flag = 1'b0;
      if (r.take) begin
         lat = 0;
         do begin
            lat++;
            nmi_n = (lat == r.xnmi) ? 1'b0 : 1'b1;
            cyc();
         end while (!smp_ld && lat < 20);
         nmi_n = 1'b1;
         chk($sformatf("v%0d_latency", idx), lat, 32'd6);
         cyc();
         chk($sformatf("v%0d_idle_after", idx), {31'd0, smp_busy}, 32'd0);
      end else begin
         nmi_n = 1'b1;
         cyc();
         chk($sformatf("v%0d_stays_idle", idx), {31'd0, smp_busy}, 32'd0);
      end
   endtask

   initial begin
      int lat;
      //          nmi0  irq_n iflag brk   s      p      pc        x  take  exp_p  exp_pc    ack
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 16'hC005, 0, 1'b1, 8'h21, 16'h8000, 2'b01};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h04, 16'h1111, 0, 1'b0, 8'h00, 16'h0000, 2'b00};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 8'h05, 16'h2000, 0, 1'b1, 8'h35, 16'h8000, 2'b11};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 16'h3456, 4, 1'b1, 8'h20, 16'h9000, 2'b10};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 16'hABCD, 0, 1'b1, 8'hE3, 16'h9000, 2'b10};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 16'h1111, 0, 1'b0, 8'h00, 16'h0000, 2'b00};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h10, 16'h4444, 0, 1'b1, 8'h20, 16'h8000, 2'b01};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hE0, 8'h00, 16'h5555, 0, 1'b1, 8'h30, 16'h8000, 2'b11};
`ifdef INT_SEQ_HIJACK_EN
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hD0, 8'h00, 16'h6666, 2, 1'b1, 8'h30, 16'h9000, 2'b10};
      tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h00, 16'h7777, 0, 1'b0, 8'h00, 16'h0000, 2'b00};
`else
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hD0, 8'h00, 16'h6666, 2, 1'b1, 8'h30, 16'h8000, 2'b11};
      tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h00, 16'h7777, 0, 1'b1, 8'h20, 16'h9000, 2'b10};
`endif

      // Power-on reset: bus parked on the reset vector, no strobes
      cyc();
      chk("rst_busy", {31'd0, smp_busy}, 32'd1);
      chk("rst_addr", {16'd0, smp_addr}, 32'h0000FFFC);
      chk("rst_we", {30'd0, smp_we, smp_sdec}, 32'd0);
      pcq.push_back({16'h1234, 2'b00});
      cyc();
      rst = 1'b0;
      wait_ld(lat);
      chk("rst_latency", lat, 32'd3);
      cyc();
      chk("rst_idle_after", {31'd0, smp_busy}, 32'd0);

      for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

      // Reset in PUSH_PCL aborts at once; boundary/brk/irq held meanwhile are ignored
      s_load = 1'b1; s_load_val = 8'hFF; pc_in = 16'hC005; p_in = 8'h01;
      cyc();
      s_load = 1'b0;
      wq.push_back({16'h01FF, 8'hC0});
      boundary = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
      cyc();
      brk = 1'b1;
      cyc();
      boundary = 1'b0; brk = 1'b0; irq_n = 1'b1;
      rst = 1'b1;
      cyc();
      chk("abort_busy", {31'd0, smp_busy}, 32'd1);
      chk("abort_we", {30'd0, smp_we, smp_sdec}, 32'd0);
      chk("abort_addr", {16'd0, smp_addr}, 32'h0000FFFC);
      pcq.push_back({16'h1234, 2'b00});
      cyc();
      rst = 1'b0;
      wait_ld(lat);
      chk("abort_rst_latency", lat, 32'd3);
      cyc();
      chk("abort_idle_after", {31'd0, smp_busy}, 32'd0);

      chk("writes_left", wq.size(), 32'd0);
      chk("pc_loads_left", pcq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
